// File: rtl/capture_pkg.sv
// ============================================================================
// Module  : capture_pkg
// Brief   : Shared state enumeration and default sizing for the capture RAM.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;

  // Default sample width, stored depth and pointer/count width
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3584;
  localparam int DEF_AW    = 12;

  // Controller states; the numeric values are visible on the STATE output
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
// ============================================================================
// Module  : sdp_ram
// Brief   : Simple dual-port RAM, one write port and one registered read
//           port, no reset so it maps onto block RAM.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3584,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write and registered read; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/capture_ram.sv
// ============================================================================
// Module  : capture_ram
// Brief   : Circular sample capture buffer. Records samples once armed,
//           keeps POST_CNT samples after a qualified trigger, then plays the
//           stored window back oldest-first through a 1-cycle-latency port.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_ram
  import capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             dvalid,
  input  logic [WIDTH-1:0] din,
  input  logic             trig,
  input  logic [AW-1:0]    post_cnt,
  input  logic             rd_req,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [1:0]       state,
  output logic             done
);

  // Last valid pointer value and the depth expressed as a count; the count
  // carries one extra bit so DEPTH == 2**AW is still representable.
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  state_t           st;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    pcnt;
  logic [AW:0]      rcnt;
  logic             wrapped;

  logic             capturing;
  logic             wr_en;
  logic             rd_en;
  logic             wptr_at_last;
  logic [AW-1:0]    wptr_nx;
  logic             wrapped_nx;
  logic [AW-1:0]    pcnt_ld;
  logic [AW-1:0]    rd_start_ptr;
  logic [AW:0]      rd_start_cnt;
  logic [WIDTH-1:0] ram_q;

  // ARM always wins: a sample or read in the ARM cycle is dropped
  assign capturing    = (st == ST_ARMED) || (st == ST_POST);
  assign wr_en        = capturing && dvalid && !arm;
  assign rd_en        = (st == ST_READ) && rd_req && !arm && (rcnt != '0);

  assign wptr_at_last = (wptr == LAST);
  assign wptr_nx      = wptr_at_last ? '0 : wptr + AW'(1);
  assign wrapped_nx   = wrapped | wptr_at_last;

  // Post-trigger counts that would exceed the buffer are limited to DEPTH-1
  assign pcnt_ld      = ({1'b0, post_cnt} >= DEPTH_C) ? LAST : post_cnt;

  // Readout window: oldest surviving sample up to the last one written
  assign rd_start_ptr = wrapped_nx ? wptr_nx : '0;
  assign rd_start_cnt = wrapped_nx ? DEPTH_C : {1'b0, wptr_nx};

  assign state = st;
  assign dout  = dout_valid ? ram_q : '0;

  // Capture/readout controller with registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= ST_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      pcnt       <= '0;
      rcnt       <= '0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (arm) begin
        st      <= ST_ARMED;
        wptr    <= '0;
        rptr    <= '0;
        pcnt    <= '0;
        rcnt    <= '0;
        wrapped <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (st)
          ST_ARMED: begin
            if (dvalid) begin
              wptr    <= wptr_nx;
              wrapped <= wrapped_nx;
              if (trig) begin
                pcnt <= pcnt_ld;
                if (pcnt_ld == '0) begin
                  st   <= ST_READ;
                  done <= 1'b1;
                  rptr <= rd_start_ptr;
                  rcnt <= rd_start_cnt;
                end else begin
                  st <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (dvalid) begin
              wptr    <= wptr_nx;
              wrapped <= wrapped_nx;
              pcnt    <= pcnt - AW'(1);
              if (pcnt == AW'(1)) begin
                st   <= ST_READ;
                done <= 1'b1;
                rptr <= rd_start_ptr;
                rcnt <= rd_start_cnt;
              end
            end
          end
          ST_READ: begin
            if (rd_en) begin
              rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
              rcnt <= rcnt - (AW + 1)'(1);
              if (rcnt == (AW + 1)'(1)) begin
                st   <= ST_IDLE;
                done <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_en),
    .raddr (rptr),
    .rdata (ram_q)
  );

endmodule

`default_nettype wire
